// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding and the bit-counter width function.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Wide enough to count 0..width-1 without wrapping early.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder/subtractor.
// The controller drives through master; the arithmetic block uses slave.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_full_adder_cell.sv
// One-bit full adder built from gate primitives.
// The serial datapath reuses this single cell for every bit position.
module full_adder_cell (
    output wire sum,
    output wire co,
    input  wire a,
    input  wire b,
    input  wire cin
);
    wire axb;
    wire gen;
    wire prop;

    xor u_x1 (axb, a, b);
    xor u_x2 (sum, axb, cin);
    and u_a1 (gen, a, b);
    and u_a2 (prop, axb, cin);
    or  u_o1 (co, gen, prop);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through a single full adder.
// Subtraction is a + ~b + 1, so the B register is loaded inverted and the carry seeded with cin^sub.
module serial_add_sub
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_add_sub_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;
    logic             accept;

    full_adder_cell u_fa (
        .sum (fa_s),
        .co  (fa_co),
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q)
    );

    assign accept = bus.start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q still holds the carry into the MSB at this point
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                if (accept) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomised checks of serial_add_sub at WIDTH=8 and WIDTH=16.
// Expected results are queued when a start is driven and popped on each done pulse.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8))  if8  ();
    serial_add_sub_if #(.WIDTH(16)) if16 ();

    serial_add_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_add_sub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    int tests = 0;
    int fails = 0;

    logic [17:0] exp8_q[$];
    logic [17:0] exp16_q[$];

    // Returns {ovf, cout, sum[15:0]} for a w-bit a +/- b +/- cin.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
        logic [16:0] mask;
        logic [16:0] full;
        logic [15:0] am;
        logic [15:0] bb;
        logic [15:0] s;
        logic        co;
        logic        ov;
        mask = (17'd1 << w) - 17'd1;
        am   = a & mask[15:0];
        bb   = (sub ? ~b : b) & mask[15:0];
        full = {1'b0, am} + {1'b0, bb} + {16'd0, cin ^ sub};
        s    = full[15:0] & mask[15:0];
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp8(input string tag);
        logic [17:0] e;
        if (exp8_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp8_q.pop_front();
            check({tag, "_sum"},  {24'd0, if8.sum}, {24'd0, e[7:0]});
            check({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, e[16]});
            check({tag, "_ovf"},  {31'd0, if8.ovf},  {31'd0, e[17]});
        end
    endtask

    // Waits up to a bounded number of edges for done; returns edges waited and busy-high samples.
    task automatic wait_done8(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!if8.done && n < 40) begin
            if (if8.busy) bc++;
            tick();
            n++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic cin, input bit timing);
        int n;
        int bc;
        if8.a = a; if8.b = b; if8.sub = sub; if8.cin = cin; if8.start = 1'b1;
        exp8_q.push_back(model(8, {8'd0, a}, {8'd0, b}, sub, cin));
        tick();
        if8.start = 1'b0;
        if8.a = ~a; if8.b = ~b; if8.sub = ~sub; if8.cin = ~cin;
        wait_done8(n, bc);
        if (!if8.done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp8_q.pop_front());
        end else begin
            cmp8(tag);
            if (timing) begin
                check({tag, "_latency"}, n, 32'd8);
                check({tag, "_busy_cycles"}, bc, 32'd8);
                check({tag, "_busy_at_done"}, {31'd0, if8.busy}, 32'd0);
            end
            tick();
            check({tag, "_done_pulse"}, {31'd0, if8.done}, 32'd0);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
        int n;
        logic [17:0] e;
        if16.a = a; if16.b = b; if16.sub = sub; if16.cin = cin; if16.start = 1'b1;
        exp16_q.push_back(model(16, a, b, sub, cin));
        tick();
        if16.start = 1'b0;
        n = 0;
        while (!if16.done && n < 40) begin
            tick();
            n++;
        end
        e = exp16_q.pop_front();
        if (!if16.done) begin
            check("w16_timeout", 32'd0, 32'd1);
        end else begin
            check("w16_latency", n, 32'd16);
            check("w16_sum",  {16'd0, if16.sum}, {16'd0, e[15:0]});
            check("w16_cout", {31'd0, if16.cout}, {31'd0, e[16]});
            check("w16_ovf",  {31'd0, if16.ovf},  {31'd0, e[17]});
        end
        tick();
    endtask

    initial begin
        int n;
        int bc;
        int extra;
        if8.start = 1'b0; if8.sub = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if16.start = 1'b0; if16.sub = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", {31'd0, if8.busy}, 32'd0);
        check("rst_done", {31'd0, if8.done}, 32'd0);
        check("rst_sum",  {24'd0, if8.sum},  32'd0);
        check("rst_cout", {31'd0, if8.cout}, 32'd0);
        check("rst_ovf",  {31'd0, if8.ovf},  32'd0);

        // Directed add/sub cases
        op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8("add_7f_cin", 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);
        op8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
        op8("sub_00_00_bin", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        check("sum_hold", {24'd0, if8.sum}, 32'h000000FF);

        // start pulsed mid-RUN must be ignored
        if8.a = 8'h21; if8.b = 8'h13; if8.sub = 1'b0; if8.cin = 1'b0; if8.start = 1'b1;
        exp8_q.push_back(model(8, 16'h0021, 16'h0013, 1'b0, 1'b0));
        tick();
        if8.start = 1'b0;
        repeat (3) tick();
        if8.a = 8'hC4; if8.b = 8'h99; if8.sub = 1'b1; if8.cin = 1'b1; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        wait_done8(n, bc);
        check("midrun_done_seen", {31'd0, if8.done}, 32'd1);
        cmp8("midrun");
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (if8.done) extra++;
        end
        check("midrun_no_extra_done", extra, 32'd0);

        // start held high across DONE: back-to-back, results 9 edges apart
        if8.a = 8'h33; if8.b = 8'h44; if8.sub = 1'b0; if8.cin = 1'b1; if8.start = 1'b1;
        exp8_q.push_back(model(8, 16'h0033, 16'h0044, 1'b0, 1'b1));
        tick();
        wait_done8(n, bc);
        check("b2b_first_latency", n, 32'd8);
        cmp8("b2b_first");
        if8.a = 8'h90; if8.b = 8'h20; if8.sub = 1'b1; if8.cin = 1'b0;
        exp8_q.push_back(model(8, 16'h0090, 16'h0020, 1'b1, 1'b0));
        tick();
        if8.start = 1'b0;
        check("b2b_busy_in_done", {31'd0, if8.busy}, 32'd1);
        wait_done8(n, bc);
        check("b2b_spacing", n + 1, 32'd9);
        cmp8("b2b_second");
        tick();

        // Reset asserted while bit 4 is pending
        if8.a = 8'h12; if8.b = 8'h34; if8.sub = 1'b0; if8.cin = 1'b0; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", {31'd0, if8.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, if8.busy}, 32'd0);
        check("arst_sum",  {24'd0, if8.sum},  32'd0);
        check("arst_cout", {31'd0, if8.cout}, 32'd0);
        check("arst_ovf",  {31'd0, if8.ovf},  32'd0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (if8.done) extra++;
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if8.done) extra++;
        end
        check("arst_no_done", extra, 32'd0);
        op8("post_rst", 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b1);

        // WIDTH=16 random sweep
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
